// File: rtl/iccm_boot_loader.sv
// Stream-fed ICCM boot loader: accepts LEN/BASE/data/CSUM frames, writes ICCM,
// and releases the core reset after a good checksum plus a fixed hold delay.
module iccm_boot_loader #(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int RELEASE_DLY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  iccm_wen,
  output logic [ADDR_WIDTH-1:0] iccm_waddr,
  output logic [XLEN-1:0]       iccm_wdata,
  output logic                  core_rst_n,
  output logic [XLEN-1:0]       reset_vector,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int HW    = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [XLEN-1:0]       DEPTH_X = XLEN'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_E = (ADDR_WIDTH+2)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR_LEN, HDR_BASE, DATA, CSUM, HOLD, RUN, ERROR} state_t;
  state_t state, state_nx;

  logic [CW-1:0]         len_q, cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [XLEN-1:0]       sum_q;
  logic [HW-1:0]         hold_q;
  logic                  xfer, len_bad, base_bad, last_data;
  logic [ADDR_WIDTH+1:0] base_end;

  assign xfer      = in_valid & in_ready;
  assign len_bad   = (in_data == '0) || (in_data > DEPTH_X);
  // BASE+LEN is evaluated one bit wider than the count so it cannot wrap.
  assign base_end  = {1'b0, in_data[ADDR_WIDTH:0]} + {1'b0, len_q};
  assign base_bad  = base_end > DEPTH_E;
  assign last_data = (cnt_q + 1'b1) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = HDR_LEN;
      HDR_LEN:  if (xfer) state_nx = len_bad ? ERROR : HDR_BASE;
      HDR_BASE: if (xfer) state_nx = base_bad ? ERROR : DATA;
      DATA:     if (xfer && last_data) state_nx = CSUM;
      CSUM:     if (xfer) begin
        if (in_data != sum_q)      state_nx = ERROR;
        else if (RELEASE_DLY == 1) state_nx = RUN;
        else                       state_nx = HOLD;
      end
      HOLD:     if (hold_q == HW'(1)) state_nx = RUN;
      RUN:      if (start) state_nx = HDR_LEN;
      ERROR:    if (start) state_nx = HDR_LEN;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      HDR_LEN, HDR_BASE, DATA, CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      HOLD:  busy = 1'b1;
      RUN: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      ERROR: err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      cnt_q        <= '0;
      base_q       <= '0;
      sum_q        <= '0;
      hold_q       <= '0;
      iccm_wen     <= 1'b0;
      iccm_waddr   <= '0;
      iccm_wdata   <= '0;
      reset_vector <= '0;
    end else begin
      iccm_wen <= 1'b0;
      case (state)
        HDR_LEN: if (xfer) len_q <= in_data[CW-1:0];
        HDR_BASE: if (xfer) begin
          base_q       <= in_data[ADDR_WIDTH-1:0];
          reset_vector <= XLEN'({in_data[ADDR_WIDTH-1:0], 2'b00});
          sum_q        <= '0;
          cnt_q        <= '0;
        end
        DATA: if (xfer) begin
          sum_q      <= sum_q + in_data;
          cnt_q      <= cnt_q + 1'b1;
          iccm_wen   <= 1'b1;
          iccm_waddr <= base_q + cnt_q[ADDR_WIDTH-1:0];
          iccm_wdata <= in_data;
        end
        // HOLD spans RELEASE_DLY-1 cycles so RUN lands RELEASE_DLY cycles after CSUM.
        CSUM: if (xfer) hold_q <= HW'(RELEASE_DLY - 1);
        HOLD: hold_q <= hold_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader with a write scoreboard fed at stimulus time.
module tb_iccm_boot_loader;
  localparam int AW    = 14;
  localparam int DLY   = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [31:0]   in_data;
  logic          in_ready, iccm_wen, core_rst_n, busy, done, err;
  logic [AW-1:0] iccm_waddr;
  logic [31:0]   iccm_wdata, reset_vector;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  wr_t           q[$];
  logic [31:0]   dq[$];
  logic [31:0]   mem [DEPTH];
  int            run_len = 0;
  int            max_run = 0;
  logic [AW-1:0] last_a = '0;

  iccm_boot_loader #(.XLEN(32), .ADDR_WIDTH(AW), .RELEASE_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .iccm_wen(iccm_wen), .iccm_waddr(iccm_waddr),
    .iccm_wdata(iccm_wdata), .core_rst_n(core_rst_n), .reset_vector(reset_vector),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: every ICCM strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    bit  have;
    if (!rst && iccm_wen) begin
      have = q.size() > 0;
      e    = have ? q.pop_front() : '0;
      total++;
      assert (have && iccm_waddr === e.a && iccm_wdata === e.d) else begin
        bad++;
        $error("FAIL iccm_write: got %0h/%0h want %0h/%0h (pending %0d)",
               iccm_waddr, iccm_wdata, e.a, e.d, have);
      end
      mem[iccm_waddr] = iccm_wdata;
      last_a = iccm_waddr;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_in_ready"},   in_ready,     0);
    check({tag, "_wen"},        iccm_wen,     0);
    check({tag, "_waddr"},      iccm_waddr,   0);
    check({tag, "_wdata"},      iccm_wdata,   0);
    check({tag, "_core_rst_n"}, core_rst_n,   0);
    check({tag, "_rvec"},       reset_vector, 0);
    check({tag, "_busy"},       busy,         0);
    check({tag, "_done"},       done,         0);
    check({tag, "_err"},        err,          0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One word transfer, optionally preceded by idle gaps carrying start noise.
  task automatic send(input logic [31:0] w, input int gap, input bit noise);
    int t;
    bit x;
    while ($urandom_range(0, 99) < gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    do begin
      x = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!x && t < 50);
    in_valid = 1'b0;
    check("xfer", x, 1);
  endtask

  task automatic send_frame(input int base, input logic [31:0] cdelta, input int gap, input bit noise);
    logic [31:0] s;
    wr_t e;
    s = '0;
    pulse_start();
    send(dq.size(), gap, noise);
    send(base, gap, noise);
    foreach (dq[i]) begin
      s += dq[i];
      e.a = AW'(base + i);
      e.d = dq[i];
      q.push_back(e);
      send(dq[i], gap, noise);
    end
    send(s + cdelta, gap, noise);
  endtask

  task automatic wait_run();
    repeat (DLY - 1) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk); #1;
    check_rst_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic good frame and release timing.
    dq = '{32'h11, 32'h22, 32'h33};
    send_frame(32'h10, 0, 0, 0);
    check("t1_hold_busy", busy, 1);
    check("t1_hold_rstn", core_rst_n, 0);
    repeat (DLY - 2) @(posedge clk); #1;
    check("t1_rstn_early", core_rst_n, 0);
    @(posedge clk); #1;
    check("t1_rstn", core_rst_n, 1);
    check("t1_done", done, 1);
    check("t1_rvec", reset_vector, 32'h40);
    check("t1_err", err, 0);
    check("t1_pending", q.size(), 0);
    foreach (dq[i]) check("t1_mem", mem[32'h10 + i], dq[i]);

    // Bad checksum, then recovery.
    send_frame(32'h10, 1, 0, 0);
    check("t2_err", err, 1);
    check("t2_rstn", core_rst_n, 0);
    repeat (8) @(posedge clk); #1;
    check("t2_rstn_held", core_rst_n, 0);
    check("t2_done", done, 0);
    send_frame(32'h10, 0, 0, 0);
    wait_run();
    check("t2_done2", done, 1);
    check("t2_err2", err, 0);

    // Header rejects.
    pulse_start();
    send(0, 0, 0);
    check("t3_len0_err", err, 1);
    check("t3_len0_ready", in_ready, 0);
    pulse_start();
    check("t3_err_clr", err, 0);
    send(DEPTH, 0, 0);
    check("t3_lenmax_ok", err, 0);
    check("t3_lenmax_busy", busy, 1);
    send(1, 0, 0);
    check("t3_base_err", err, 1);

    // Full-depth frame at full throughput with wrapping checksum.
    dq.delete();
    repeat (DEPTH) dq.push_back(32'hFFFF_FFFF);
    max_run = 0;
    send_frame(0, 0, 0, 0);
    wait_run();
    check("t4_done", done, 1);
    check("t4_run", max_run, DEPTH);
    check("t4_last_addr", last_a, DEPTH - 1);
    check("t4_pending", q.size(), 0);

    // Random valid gaps with start noise.
    dq.delete();
    repeat (12) dq.push_back($urandom);
    send_frame(32'h200, 0, 40, 1);
    wait_run();
    check("t5_done", done, 1);
    check("t5_rvec", reset_vector, 32'h800);
    check("t5_pending", q.size(), 0);
    foreach (dq[i]) check("t5_mem", mem[32'h200 + i], dq[i]);

    // Reset in the middle of DATA.
    pulse_start();
    send(6, 0, 0);
    send(32'h31, 0, 0);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.a = AW'(32'h31 + i);
      e.d = 32'hA0 + i;
      q.push_back(e);
      send(32'hA0 + i, 0, 0);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_rst_outs("t6");
    check("t6_pending", q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dq = '{32'hDEAD_BEEF, 32'h1234_5678};
    send_frame(32'h30, 0, 0, 0);
    wait_run();
    check("t6_done", done, 1);
    check("t6_rvec", reset_vector, 32'hC0);
    foreach (dq[i]) check("t6_mem", mem[32'h30 + i], dq[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
